cla_nibble_seq_adder: RTL

//  Sequencing controller that adds two WIDTH-bit operands with a single shared cla_4b,
//  one nibble per clock, LSB nibble first, carry held in a register between nibbles.

---
 rtl/cla_seq_pkg.sv | 18 +
 rtl/cla_4b.sv | 36 +++
 rtl/cla_nibble_seq_adder.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/cla_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cla_seq_pkg
// Brief    : Shared types and constants for the nibble-serial CLA adder.
// Revision : 1.0
// ============================================================================
package cla_seq_pkg;

    localparam int NIBBLE_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        DONE = 2'd2
    } cla_seq_state_t;

endpackage : cla_seq_pkg
`default_nettype wire

// File: rtl/cla_4b.sv
`default_nettype none
// ============================================================================
// Module   : cla_4b
// Brief    : 4-bit carry-lookahead adder, fully combinational.
// Revision : 1.0
// ============================================================================
module cla_4b (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       c_in,
    output logic [3:0] s,
    output logic       c_out
);

    logic [3:0] w_g;
    logic [3:0] w_p;
    logic [4:0] w_c;

    assign w_g = a & b;
    assign w_p = a ^ b;

    // Each carry is expanded in terms of c_in so no carry ripples.
    assign w_c[0] = c_in;
    assign w_c[1] = w_g[0] | (w_p[0] & c_in);
    assign w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & c_in);
    assign w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                  | (w_p[2] & w_p[1] & w_p[0] & c_in);
    assign w_c[4] = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
                  | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
                  | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & c_in);

    assign s     = w_p ^ w_c[3:0];
    assign c_out = w_c[4];

endmodule : cla_4b
`default_nettype wire

// File: rtl/cla_nibble_seq_adder.sv
`default_nettype none
// ============================================================================
// Module   : cla_nibble_seq_adder
// Brief    : WIDTH-bit adder built from one shared cla_4b, one nibble per clock,
//            LSB first, with valid/ready handshakes on both sides.
// Revision : 1.0
// ============================================================================
module cla_nibble_seq_adder
    import cla_seq_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             c_out
);

    localparam int NIB   = WIDTH / NIBBLE_W;
    localparam int IDX_W = (NIB > 1) ? $clog2(NIB) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIB - 1);

    generate
        if ((WIDTH < NIBBLE_W) || ((WIDTH % NIBBLE_W) != 0)) begin : g_bad_width
            $error("cla_nibble_seq_adder: WIDTH must be a multiple of 4 and >= 4");
        end
    endgenerate

    cla_seq_state_t r_state;
    cla_seq_state_t w_state_nxt;

    logic             r_alive;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_sum;
    logic             r_carry;
    logic             r_c_out;
    logic [IDX_W-1:0] r_nib_idx;

    logic [NIBBLE_W-1:0] w_nib_a;
    logic [NIBBLE_W-1:0] w_nib_b;
    logic [NIBBLE_W-1:0] w_nib_s;
    logic                w_nib_c;
    logic                w_accept;
    logic                w_last;

    assign w_nib_a = r_a[NIBBLE_W*r_nib_idx +: NIBBLE_W];
    assign w_nib_b = r_b[NIBBLE_W*r_nib_idx +: NIBBLE_W];
    assign w_last  = (r_nib_idx == LAST_IDX);

    cla_4b u_cla_4b (
        .a     (w_nib_a),
        .b     (w_nib_b),
        .c_in  (r_carry),
        .s     (w_nib_s),
        .c_out (w_nib_c)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // in_ready/out_valid depend only on registered state, never on in_valid/out_ready.
    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        w_accept    = 1'b0;
        case (r_state)
            IDLE: begin
                in_ready = r_alive;
                if (in_valid && r_alive) begin
                    w_accept    = 1'b1;
                    w_state_nxt = ADD;
                end
            end
            ADD: begin
                if (w_last) begin
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // r_alive keeps in_ready low until the first edge after reset release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_alive   <= 1'b0;
            r_a       <= '0;
            r_b       <= '0;
            r_sum     <= '0;
            r_carry   <= 1'b0;
            r_c_out   <= 1'b0;
            r_nib_idx <= '0;
        end else begin
            r_alive <= 1'b1;
            if (w_accept) begin
                r_a       <= a;
                r_b       <= b;
                r_carry   <= c_in;
                r_nib_idx <= '0;
            end
            if (r_state == ADD) begin
                r_sum[NIBBLE_W*r_nib_idx +: NIBBLE_W] <= w_nib_s;
                r_carry                               <= w_nib_c;
                if (w_last) begin
                    r_nib_idx <= '0;
                    r_c_out   <= w_nib_c;
                end else begin
                    r_nib_idx <= r_nib_idx + 1'b1;
                end
            end
        end
    end

    assign sum   = r_sum;
    assign c_out = r_c_out;

endmodule : cla_nibble_seq_adder
`default_nettype wire
